seq_approx_divider: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 18 +
 rtl/seq_approx_divider.sv | 124 ++++++++++++
 tb/tb_seq_approx_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and sizing helpers for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int N_DEF     = 4;
    localparam int TRUNC_DEF = 0;

    function automatic int cnt_width(input int n);
        return (2 * n > 2) ? $clog2(2 * n) : 1;
    endfunction

    function automatic int iter_count(input int n, input int trunc);
        return 2 * n - trunc;
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);
    localparam int ITER  = iter_count(N_DEF, TRUNC_DEF);

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, conditional subtract).
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   part_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   part_out,
    output logic         q_bit
);

    logic [N+1:0] sh;

    assign sh       = {part_in, bit_in};
    assign q_bit    = sh >= (N+2)'(divisor);
    assign part_out = q_bit ? (N+1)'(sh - (N+2)'(divisor)) : (N+1)'(sh);

endmodule

// File: rtl/seq_approx_divider.sv
// seq_approx_divider: iterative radix-2 restoring divider, one quotient bit per clock,
// with optional truncation of the last quotient bits.
module seq_approx_divider
    import div_pkg::*;
#(
    parameter int N     = 4,
    parameter int TRUNC = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = cnt_width(N);
    localparam int IT = iter_count(N, TRUNC);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     part_q, part_d;
    logic [2*N-1:0] dd_q, dd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dz_q, dz_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [N:0]     part_nx;
    logic           q_bit;
    logic [2*N-1:0] dd_nx;

    div_step #(.N(N)) u_step (
        .part_in (part_q),
        .bit_in  (dd_q[2*N-1]),
        .divisor (dvs_q),
        .part_out(part_nx),
        .q_bit   (q_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign dd_nx = {dd_q[2*N-2:0], q_bit};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        part_d      = part_q;
        dd_d        = dd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dd_d   = dividend;
                dvs_d  = divisor;
                part_d = '0;
                cnt_d  = CW'(IT - 1);
                dz_d   = divisor == '0;
                if (divisor == '0) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dividend[N-1:0];
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                part_d = part_nx;
                dd_d   = dd_nx;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = dd_nx << TRUNC;
                    remainder_d = (TRUNC == 0) ? part_nx[N-1:0] : '0;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            part_q      <= '0;
            dd_q        <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            part_q      <= part_d;
            dd_q        <= dd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// tb_seq_approx_divider: exact (TRUNC=0) and truncated (TRUNC=2) dividers share one stimulus
// stream; a transaction-level model predicts handshake timing and results for both.
module tb_seq_approx_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;

    logic       ir0, ov0, z0, ir1, ov1, z1;
    logic [7:0] q0, q1;
    logic [3:0] r0, r1;

    int tot = 0;
    int pass = 0;

    seq_approx_divider #(.N(4), .TRUNC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
        .dividend(dividend), .divisor(divisor), .out_valid(ov0), .out_ready(out_ready),
        .quotient(q0), .remainder(r0), .div_by_zero(z0)
    );

    seq_approx_divider #(.N(4), .TRUNC(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .dividend(dividend), .divisor(divisor), .out_valid(ov1), .out_ready(out_ready),
        .quotient(q1), .remainder(r1), .div_by_zero(z1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    function automatic logic [7:0] mq(input logic [7:0] d_in, input logic [3:0] d_or, input int t);
        int qi;
        if (d_or == 0) return 8'hFF;
        qi = int'(d_in) / int'(d_or);
        return 8'(qi & ~((1 << t) - 1));
    endfunction

    function automatic logic [3:0] mr(input logic [7:0] d_in, input logic [3:0] d_or, input int t);
        if (d_or == 0) return d_in[3:0];
        if (t != 0) return 4'd0;
        return 4'(int'(d_in) % int'(d_or));
    endfunction

    function automatic int mlat(input logic [3:0] d_or, input int t);
        return (d_or == 0) ? 0 : 8 - t;
    endfunction

    // Model: each unit is either free or holding one transaction due at a given edge count.
    int         cyc = 0;
    bit         busy [2] = '{0, 0};
    bit         fresh [2] = '{1, 1};
    int         due [2] = '{0, 0};
    logic [7:0] eq [2];
    logic [3:0] er [2];
    bit         ez [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                busy[k]  <= 1'b0;
                fresh[k] <= 1'b1;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (busy[k] && cyc >= due[k] && out_ready) begin
                    busy[k] <= 1'b0;
                end else if (!busy[k] && in_valid) begin
                    busy[k]  <= 1'b1;
                    fresh[k] <= 1'b0;
                    due[k]   <= cyc + 1 + mlat(divisor, k * 2);
                    eq[k]    <= mq(dividend, divisor, k * 2);
                    er[k]    <= mr(dividend, divisor, k * 2);
                    ez[k]    <= divisor == 0;
                end
            end
        end
    end

    task automatic chk_inst(input int k, input logic ir, input logic ov, input logic [7:0] q,
                            input logic [3:0] r, input logic z);
        bit eov;
        eov = busy[k] && cyc >= due[k];
        check($sformatf("in_ready%0d", k), ir, !busy[k]);
        check($sformatf("out_valid%0d", k), ov, eov);
        if (eov) begin
            check($sformatf("quotient%0d", k), q, eq[k]);
            check($sformatf("remainder%0d", k), r, er[k]);
            check($sformatf("div_by_zero%0d", k), z, ez[k]);
        end else if (fresh[k]) begin
            check($sformatf("reset_q%0d", k), q, 0);
            check($sformatf("reset_r%0d", k), r, 0);
            check($sformatf("reset_dz%0d", k), z, 0);
        end
    endtask

    always @(negedge clk) begin
        chk_inst(0, ir0, ov0, q0, r0, z0);
        chk_inst(1, ir1, ov1, q1, r1, z1);
    end

    task automatic op(input logic [7:0] d_in, input logic [3:0] d_or, input int k, input int hold,
                      input bit lit, input logic [7:0] xq, input logic [3:0] xr, input bit xz,
                      input int xl);
        int n;
        @(negedge clk);
        dividend  = d_in;
        divisor   = d_or;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        n = 0;
        while (!(k == 1 ? ov1 : ov0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("result_valid", k == 1 ? ov1 : ov0, 1);
        if (lit) begin
            check("latency", n, xl);
            check("lit_q", k == 1 ? q1 : q0, xq);
            check("lit_r", k == 1 ? r1 : r0, xr);
            check("lit_dz", k == 1 ? z1 : z0, xz);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 2);
            dividend = 8'd99;
            divisor  = 4'd5;
        end
        in_valid = 1'b0;
        if (lit && hold > 0) begin
            check("held_q", q0, xq);
            check("held_r", r0, xr);
            check("held_in_ready", ir0, 0);
        end
        out_ready = 1'b1;
        n = 0;
        while (!(ir0 && ir1) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_ready", ir0 && ir1, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ir0, 1);
        check("rst_out_valid", ov0, 0);
        check("rst_q", q0, 0);
        @(negedge clk);
        rst = 1'b0;

        op(8'd200, 4'd7, 0, 0, 1, 8'd28, 4'd4, 1'b0, 8);
        op(8'd255, 4'd1, 0, 0, 1, 8'd255, 4'd0, 1'b0, 8);
        op(8'd15, 4'd15, 0, 0, 1, 8'd1, 4'd0, 1'b0, 8);
        op(8'd3, 4'd9, 0, 0, 1, 8'd0, 4'd3, 1'b0, 8);
        op(8'd77, 4'd0, 0, 0, 1, 8'd255, 4'd13, 1'b1, 0);
        op(8'd200, 4'd7, 0, 5, 1, 8'd28, 4'd4, 1'b0, 8);

        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", ov0, 0);
        check("midrun_rst_in_ready", ir0, 1);
        check("midrun_rst_q", q0, 0);
        check("midrun_rst_r", r0, 0);
        @(negedge clk);
        rst = 1'b0;
        op(8'd100, 4'd10, 0, 0, 1, 8'd10, 4'd0, 1'b0, 8);

        op(8'd29, 4'd3, 1, 0, 1, 8'd8, 4'd0, 1'b0, 6);
        op(8'd77, 4'd0, 1, 0, 1, 8'd255, 4'd13, 1'b1, 0);

        for (int i = 0; i < 30; i++)
            op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 0, 0, 0, 8'd0, 4'd0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
